sp_ram_req_ctrl: RTL and testbench

- Request front-end that sits directly upstream of the single-port cache RAM (1-cycle registered read, write-or-read per cycle).
- Accepts independent valid/ready read and write request channels and arbitrates them onto the one RAM port.
- Tracks the 1-cycle read latency and returns read data through a 2-entry response buffer with valid/ready backpressure.
- Used by cache tag/data arrays so callers never see the RAM's en/we timing.

---
 rtl/sp_ram_req_ctrl_pkg.sv | 30 +++
 rtl/sp_ram_rsp_fifo.sv | 71 +++++++
 rtl/sp_ram_req_ctrl.sv | 152 +++++++++++++++
 tb/tb_sp_ram_req_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_req_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_req_ctrl_pkg
// Shared types and constants for the single-port RAM request front-end.
//   gnt_side_e : which request channel owns the RAM port in a given cycle
//   RSP_DEPTH  : response buffer depth, which is also the outstanding-read limit
//   CNT_W      : width of the response buffer occupancy count
//   STAT_W     : width of the optional statistics counters
//   sat_inc()  : saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package sp_ram_req_ctrl_pkg;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_side_e;

    localparam int RSP_DEPTH = 2;
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int STAT_W    = 32;

    // The counter holds at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val,
                                                  input logic              en);
        if (en && (val != '1)) begin
            return val + STAT_W'(1);
        end
        return val;
    endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// -----------------------------------------------------------------------------
// sp_ram_rsp_fifo
// Two-entry synchronous FIFO holding read responses. Entry 0 is always the
// head, so the head data comes straight from a register with no read mux.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_data into the FIFO this cycle
//   push_data  : data to enqueue
//   pop        : remove the head entry this cycle (ignored when empty)
//   count      : number of valid entries (0..2)
//   head_data  : oldest entry, meaningful only when count != 0
// -----------------------------------------------------------------------------
module sp_ram_rsp_fifo
    import sp_ram_req_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic [DATA_W-1:0] mem_d [RSP_DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              pop_eff;

    always_comb begin
        // NOTE: every signal assigned here receives a default first, so no path leaves it unassigned and no latch is inferred.
        mem_d   = mem_q;
        count_d = count_q;
        pop_eff = pop && (count_q != '0);

        // NOTE: blocking assignments here are deliberate: the push below uses the count already adjusted by the pop.
        if (pop_eff) begin
            mem_d[0] = mem_q[1];
            count_d  = count_q - CNT_W'(1);
        end
        if (push) begin
            mem_d[count_d[0]] = push_data;
            count_d           = count_d + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: the data entries are deliberately left without reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count     = count_q;
    assign head_data = mem_q[0];

    // The upstream read-eligibility logic must never let the buffer overflow.
    assert property (@(posedge clk) disable iff (rst)
                     !(push && !pop_eff && (count_q == CNT_W'(RSP_DEPTH))));

endmodule

// File: rtl/sp_ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// sp_ram_req_ctrl
// Front-end for a single-port RAM with a 1-cycle registered read. It arbitrates
// independent read and write valid/ready channels onto the one RAM port and
// returns read data in issue order through a 2-entry response buffer.
// Ports:
//   ap_clk, areset          : clock, asynchronous active-high reset
//   wr_valid/ready/addr/data: write request channel
//   rd_valid/ready/addr     : read request channel
//   rsp_valid/ready/data    : read response channel
//   ram_en/we/addr/din/dout : RAM port; ram_dout is valid the cycle after a read
// Optional build macro SP_RAM_CTRL_STATS_EN adds saturating counters:
//   stat_rd_cnt, stat_wr_cnt, stat_stall_cnt
// -----------------------------------------------------------------------------
module sp_ram_req_ctrl
    import sp_ram_req_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef SP_RAM_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_rd_cnt,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

    gnt_side_e        rr_last_q;
    gnt_side_e        rr_last_d;
    logic             rd_inflight_q;
    logic             rd_inflight_d;
    logic [CNT_W-1:0] rsp_count;
    logic [CNT_W:0]   rd_occupancy;
    logic             rsp_pop;
    logic             rd_ok;
    logic             grant_rd;
    logic             grant_wr;

    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Arbitration. The occupancy counts responses held in the buffer plus the
    // read in flight, minus the entry leaving this cycle; a newly granted read
    // lands two edges later, by which time that entry has gone. Subtracting
    // the pop is what allows one read per cycle while rsp_ready is held high.
    always_comb begin
        rd_occupancy = {1'b0, rsp_count}
                     + {{CNT_W{1'b0}}, rd_inflight_q}
                     - {{CNT_W{1'b0}}, rsp_pop};
        rd_ok    = (rd_occupancy < (CNT_W + 1)'(RSP_DEPTH));
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (!areset) begin
            if (wr_valid && rd_valid && rd_ok) begin
                grant_rd = (rr_last_q == GNT_WR);
                grant_wr = !grant_rd;
            end else if (wr_valid) begin
                grant_wr = 1'b1;
            end else if (rd_valid && rd_ok) begin
                grant_rd = 1'b1;
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (grant_rd) begin
            rr_last_d = GNT_RD;
        end else if (grant_wr) begin
            rr_last_d = GNT_WR;
        end
        rd_inflight_d = grant_rd;
    end

    // Resetting to GNT_WR makes the read side win the first tie.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            rr_last_q     <= GNT_WR;
            rd_inflight_q <= 1'b0;
        end else begin
            rr_last_q     <= rr_last_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    // The RAM accepts unconditionally, so ready may safely depend on valid.
    assign wr_ready = grant_wr;
    assign rd_ready = grant_rd;
    assign ram_en   = grant_wr | grant_rd;
    assign ram_we   = grant_wr;
    assign ram_addr = grant_wr ? wr_addr : rd_addr;
    assign ram_din  = wr_data;

    sp_ram_rsp_fifo #(
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk       (ap_clk),
        .rst       (areset),
        .push      (rd_inflight_q),
        .push_data (ram_dout),
        .pop       (rsp_pop),
        .count     (rsp_count),
        .head_data (rsp_data)
    );

`ifdef SP_RAM_CTRL_STATS_EN
    logic [STAT_W-1:0] stat_rd_cnt_q,    stat_rd_cnt_d;
    logic [STAT_W-1:0] stat_wr_cnt_q,    stat_wr_cnt_d;
    logic [STAT_W-1:0] stat_stall_cnt_q, stat_stall_cnt_d;

    always_comb begin
        stat_rd_cnt_d    = sat_inc(stat_rd_cnt_q, grant_rd);
        stat_wr_cnt_d    = sat_inc(stat_wr_cnt_q, grant_wr);
        stat_stall_cnt_d = sat_inc(stat_stall_cnt_q, rd_valid && !rd_ok);
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            stat_rd_cnt_q    <= '0;
            stat_wr_cnt_q    <= '0;
            stat_stall_cnt_q <= '0;
        end else begin
            stat_rd_cnt_q    <= stat_rd_cnt_d;
            stat_wr_cnt_q    <= stat_wr_cnt_d;
            stat_stall_cnt_q <= stat_stall_cnt_d;
        end
    end

    assign stat_rd_cnt    = stat_rd_cnt_q;
    assign stat_wr_cnt    = stat_wr_cnt_q;
    assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_req_ctrl
// Directed bench for sp_ram_req_ctrl with a behavioural 1-cycle RAM attached.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Statistics checks are compiled when SP_RAM_CTRL_STATS_EN is set.
// -----------------------------------------------------------------------------
module tb_sp_ram_req_ctrl;

    localparam int DW = 8;
    localparam int AW = 14;

    logic          ap_clk = 1'b0;
    logic          areset;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, ram_addr;
    logic [DW-1:0] wr_data, rsp_data, ram_din, ram_dout;
    logic          rsp_valid, rsp_ready, ram_en, ram_we;
`ifdef SP_RAM_CTRL_STATS_EN
    logic [31:0]   stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 ap_clk = ~ap_clk;

    // Behavioural single-port RAM: registered read, write-or-read per cycle.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge ap_clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout          <= ram_mem[ram_addr];
        end
    end

    sp_ram_req_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef SP_RAM_CTRL_STATS_EN
        ,
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    task automatic idle_inputs();
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        areset = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1 areset = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        next_cycle();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        areset    = 1'b1;
        wr_valid  = 1'b1;
        rd_valid  = 1'b1;
        rsp_ready = 1'b1;
        #2;
        tests_run++;
        if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        tests_run++;
        if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        @(posedge ap_clk);
        @(negedge ap_clk);
        tests_run++;
        if (ram_en !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
        @(posedge ap_clk);
        #1;
        idle_inputs();
        areset = 1'b0;
        next_cycle();
    endtask

    task automatic test_write_read();
        wr_valid = 1'b1;
        wr_addr  = 14'h010;
        wr_data  = 8'hA5;
        @(negedge ap_clk);
        tests_run++;
        if (wr_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 14'h010) begin
            tests_failed++;
            $display("FAIL wr_grant: got ready=%b we=%b addr=%h want 1 1 010", wr_ready, ram_we, ram_addr);
        end
        next_cycle();
        wr_valid  = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 14'h010;
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        tests_run++;
        if (rd_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_grant: got ready=%b en=%b we=%b want 1 1 0", rd_ready, ram_en, ram_we);
        end
        next_cycle();
        rd_valid = 1'b0;
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rsp_early: got %b want 0", rsp_valid); end
        next_cycle();
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rsp_latency: got valid=%b data=%h want 1 a5", rsp_valid, rsp_data);
        end
        next_cycle();
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rsp_pop: got %b want 0", rsp_valid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_arbitration();
        logic exp_rd;
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr  = 14'h100 + 14'(i);
            wr_data  = 8'(i);
            rd_valid = 1'b1;
            rd_addr  = 14'h010;
            exp_rd   = (i % 2 == 0);
            @(negedge ap_clk);
            tests_run++;
            if (rd_ready !== exp_rd || wr_ready !== !exp_rd) begin
                tests_failed++;
                $display("FAIL arb_cycle%0d: got rd=%b wr=%b want rd=%b wr=%b", i, rd_ready, wr_ready, exp_rd, !exp_rd);
            end
            tests_run++;
            if (ram_we !== !exp_rd) begin
                tests_failed++;
                $display("FAIL arb_we%0d: got %b want %b", i, ram_we, !exp_rd);
            end
            next_cycle();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (4) next_cycle();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        do_write(14'd1, 8'h11);
        do_write(14'd2, 8'h22);
        do_write(14'd3, 8'h33);
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 14'd1;
        @(negedge ap_clk);
        tests_run++;
        if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_rd1: got %b want 1", rd_ready); end
        next_cycle();
        rd_addr = 14'd2;
        @(negedge ap_clk);
        tests_run++;
        if (rd_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_rd2: got %b want 1", rd_ready); end
        next_cycle();
        rd_addr = 14'd3;
        @(negedge ap_clk);
        tests_run++;
        if (rd_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_stall_c2: got %b want 0", rd_ready); end
        next_cycle();
        @(negedge ap_clk);
        tests_run++;
        if (rd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL bp_full: got rd_ready=%b valid=%b data=%h want 0 1 11", rd_ready, rsp_valid, rsp_data);
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        tests_run++;
        if (rd_ready !== 1'b1 || rsp_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL bp_release: got rd_ready=%b data=%h want 1 11", rd_ready, rsp_data);
        end
        next_cycle();
        rd_valid = 1'b0;
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin
            tests_failed++;
            $display("FAIL bp_second: got valid=%b data=%h want 1 22", rsp_valid, rsp_data);
        end
        next_cycle();
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h33) begin
            tests_failed++;
            $display("FAIL bp_third: got valid=%b data=%h want 1 33", rsp_valid, rsp_data);
        end
        next_cycle();
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty: got %b want 0", rsp_valid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic       exp_valid;
        logic [7:0] exp_data;
        int         handshakes;
        apply_reset();
        for (int i = 0; i < 8; i++) do_write(14'(i), 8'h40 + 8'(i));
        rsp_ready  = 1'b1;
        handshakes = 0;
        for (int c = 0; c < 12; c++) begin
            rd_valid = (c < 8);
            rd_addr  = 14'(c % 8);
            @(negedge ap_clk);
            if (rd_valid && rd_ready) handshakes++;
            exp_valid = (c >= 2) && (c < 10);
            tests_run++;
            if (rsp_valid !== exp_valid) begin
                tests_failed++;
                $display("FAIL b2b_valid_c%0d: got %b want %b", c, rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                exp_data = 8'h40 + 8'(c - 2);
                tests_run++;
                if (rsp_data !== exp_data) begin
                    tests_failed++;
                    $display("FAIL b2b_data_c%0d: got %h want %h", c, rsp_data, exp_data);
                end
            end
            next_cycle();
        end
        tests_run++;
        if (handshakes !== 8) begin tests_failed++; $display("FAIL b2b_handshakes: got %0d want 8", handshakes); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 14'd5;
        next_cycle();
        rd_addr = 14'd6;
        next_cycle();
        rd_valid = 1'b0;
        @(negedge ap_clk);
        tests_run++;
        if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre: got %b want 1", rsp_valid); end
        areset = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_async: got %b want 0", rsp_valid); end
        @(posedge ap_clk);
        #1;
        areset    = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge ap_clk);
            tests_run++;
            if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_stale_c%0d: got %b want 0", c, rsp_valid); end
            next_cycle();
        end
        idle_inputs();
    endtask

`ifdef SP_RAM_CTRL_STATS_EN
    task automatic test_stats();
        apply_reset();
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 14'd1;
        repeat (4) next_cycle();
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) next_cycle();
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            rd_addr  = 14'(i);
            next_cycle();
        end
        rd_valid = 1'b0;
        repeat (3) next_cycle();
        for (int i = 0; i < 3; i++) do_write(14'h200 + 14'(i), 8'(i));
        @(negedge ap_clk);
        tests_run++;
        if (stat_wr_cnt !== 32'd3) begin tests_failed++; $display("FAIL stat_wr: got %0d want 3", stat_wr_cnt); end
        tests_run++;
        if (stat_rd_cnt !== 32'd5) begin tests_failed++; $display("FAIL stat_rd: got %0d want 5", stat_rd_cnt); end
        tests_run++;
        if (stat_stall_cnt !== 32'd2) begin tests_failed++; $display("FAIL stat_stall: got %0d want 2", stat_stall_cnt); end
        force dut.stat_wr_cnt_q = 32'hFFFF_FFFF;
        @(posedge ap_clk);
        #1;
        release dut.stat_wr_cnt_q;
        do_write(14'h210, 8'h01);
        do_write(14'h211, 8'h02);
        @(negedge ap_clk);
        tests_run++;
        if (stat_wr_cnt !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL stat_sat: got %h want ffffffff", stat_wr_cnt); end
        next_cycle();
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef SP_RAM_CTRL_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
